// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with pipeline stall/flush.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow go straight from accept to DONE.
module div_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] spec_val_q, spec_val_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            spec_q, spec_d;

    logic            accept;
    logic            op_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf;
    logic [XLEN-1:0] spec_val_in;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            step_ok;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fin_quo, fin_rem, fin_val;

    // aluop[1] selects remainder, aluop[0] selects unsigned.
    assign accept    = (state_q == IDLE) && start && (aluop[4:2] == 3'b011) && !flush;
    assign op_signed = !aluop[0];
    assign a_neg     = op_signed && op1[XLEN-1];
    assign b_neg     = op_signed && op2[XLEN-1];
    assign a_mag     = a_neg ? -op1 : op1;
    assign b_mag     = b_neg ? -op2 : op2;
    assign div_zero  = (op2 == '0);
    assign ovf       = op_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

    // Signed overflow returns the dividend itself as quotient, zero as remainder.
    assign spec_val_in = div_zero ? (aluop[1] ? op1 : '1) : (aluop[1] ? '0 : op1);

    assign shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
    assign step_ok  = !trial[XLEN+1];
    assign step_rem = step_ok ? trial[XLEN:0] : shifted;
    assign step_quo = {quo_q[XLEN-2:0], step_ok};

    assign fin_quo = neg_quo_q ? -step_quo : step_quo;
    assign fin_rem = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
    assign fin_val = spec_q ? spec_val_q : (is_rem_q ? fin_rem : fin_quo);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        is_rem_d   = is_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        spec_d     = spec_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d   = aluop[1];
                    quo_d      = a_mag;
                    dvs_d      = b_mag;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    spec_d     = div_zero || ovf;
                    spec_val_d = spec_val_in;
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = BUSY;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero || ovf) begin
                        state_d  = DONE;
                        result_d = spec_val_in;
                    end
`endif
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d  = DONE;
                        result_d = fin_val;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            spec_val_q <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            is_rem_q   <= is_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            spec_q     <= spec_d;
        end
    end

    assign stall  = accept || (state_q == BUSY);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: vector table, randomized ops against an arithmetic reference,
// and hand sequences for flush, reset and non-divide starts.
module tb_div_sequencer;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [4:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;
    bit          early;

    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_REM  = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    div_sequencer #(.XLEN(32), .ITER(32)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .aluop(aluop),
        .op1(op1), .op2(op2), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V semantics straight from the ISA rules, using language division.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            OP_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            OP_REM: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    // Caller is positioned at a negedge; this cycle is the accept cycle.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        int cyc;
        bit seen;
        bit stall_ok;
        lat = (early && is_special(op, a, b)) ? 1 : 33;
        exp_q.push_back(exp);
        start = 1'b1; aluop = op; op1 = a; op2 = b; flush = 1'b0;
        #1;
        check("stall_accept", {31'd0, stall}, 32'd1);
        seen = 1'b0; stall_ok = 1'b1; cyc = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge CLK);
            cyc = k;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!stall || !busy) stall_ok = 1'b0;
                start = 1'($urandom_range(0, 1));
                aluop = 5'(12 + $urandom_range(0, 3));
                op1   = $urandom;
                op2   = $urandom;
            end
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
        check("stall_busy_window", {31'd0, stall_ok}, 32'd1);
        if (seen) begin
            check("stall_at_done", {31'd0, stall}, 32'd0);
            check("result", result, exp_q.pop_front());
            last_result = exp;
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
`ifdef DIV_EARLY_OUT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        vecs[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1] = '{OP_REMU, 32'd100,        32'd7,          32'd2};
        vecs[2] = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};
        vecs[3] = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};
        vecs[4] = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[5] = '{OP_REM,  32'd5,          32'd0,          32'd5};
        vecs[6] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[7] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[8] = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};

        RESET = 1'b1; start = 1'b0; aluop = 5'd0; op1 = 32'd0; op2 = 32'd0; flush = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 5'(12 + $urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: begin
                    ra = $urandom_range(0, 5000);
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    rb = $urandom_range(1, 50);
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: rb = $urandom;
            endcase
            @(negedge CLK);
            run_op(rop, ra, rb, ref_result(rop, ra, rb));
        end

        // Flush in cycle 10 of a DIV: no done, result held, next op accepts in cycle 11.
        @(negedge CLK);
        start = 1'b1; aluop = OP_DIV; op1 = 32'd1000; op2 = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_result_held", result, last_result);
        run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333);

        // Flush in IDLE blocks an accept in the same cycle.
        @(negedge CLK);
        start = 1'b1; aluop = OP_DIV; op1 = 32'd9; op2 = 32'd2; flush = 1'b1;
        #1;
        check("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);

        // Reset in cycle 20 of an operation clears everything.
        @(negedge CLK);
        start = 1'b1; aluop = OP_REMU; op1 = 32'd77; op2 = 32'd5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("midreset_stall", {31'd0, stall}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);

        // Non-divide aluop never accepts.
        start = 1'b1; aluop = 5'b00000; op1 = 32'd3; op2 = 32'd4;
        #1;
        check("nondiv_stall", {31'd0, stall}, 32'd0);
        @(negedge CLK);
        start = 1'b0;
        check("nondiv_busy", {31'd0, busy}, 32'd0);
        check("nondiv_result", result, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
